// File: rtl/port_share_pkg.sv
// Shared constants for the two-requester port-share arbiter: state encoding,
// mux select values and beat-counter width.
package port_share_pkg;
    localparam int CNT_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_OWN_A = 2'b01;
    localparam logic [1:0] ST_OWN_B = 2'b10;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;
endpackage

// File: rtl/port_share_arbiter_mux.sv
// 32-bit 2:1 data mux placed behind the arbiter; sel = 0 passes inA.
module Mux32Bit2To1 (
    input  logic [31:0] inA,
    input  logic [31:0] inB,
    input  logic        sel,
    output logic [31:0] out
);
    assign out = sel ? inB : inA;
endmodule

// File: rtl/port_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit port between requesters A and B,
// with bursts capped at BURST_MAX beats and a valid/ready handshake downstream.
module port_share_arbiter
    import port_share_pkg::*;
#(
    parameter int unsigned BURST_MAX = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ReqA,
    input  logic        ReqB,
    input  logic        LastA,
    input  logic        LastB,
    input  logic [31:0] DataA,
    input  logic [31:0] DataB,
    input  logic        Ready,
    output logic        GntA,
    output logic        GntB,
    output logic        Sel,
    output logic [31:0] Out,
    output logic        OutValid
);
    // state | meaning
    // IDLE  | nobody owns the port, Sel parked on A
    // OWN_A | A owns the port, A beats counted in cnt
    // OWN_B | B owns the port, B beats counted in cnt

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prio_q, prio_d;

    logic             own_a, own_b;
    logic             beat_a, beat_b;
    logic [CNT_W-1:0] cnt_inc;
    logic             cap_hit;
    logic             rel_a, rel_b;

    assign own_a   = (state_q == ST_OWN_A);
    assign own_b   = (state_q == ST_OWN_B);
    assign beat_a  = own_a & ReqA & Ready;
    assign beat_b  = own_b & ReqB & Ready;
    assign cnt_inc = cnt_q + 1'b1;
    assign cap_hit = (cnt_inc == CNT_W'(BURST_MAX));

    // A withdrawn request releases even without a beat.
    assign rel_a = (beat_a & (LastA | cap_hit)) | (own_a & ~ReqA);
    assign rel_b = (beat_b & (LastB | cap_hit)) | (own_b & ~ReqB);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        case (state_q)
            ST_IDLE: begin
                if (ReqA && (!ReqB || prio_q == SEL_A)) begin
                    state_d = ST_OWN_A;
                end else if (ReqB) begin
                    state_d = ST_OWN_B;
                end
            end
            ST_OWN_A: begin
                if (rel_a) begin
                    cnt_d  = '0;
                    prio_d = SEL_B;
                    if (ReqB)      state_d = ST_OWN_B;
                    else if (ReqA) state_d = ST_OWN_A;
                    else           state_d = ST_IDLE;
                end else if (beat_a) begin
                    cnt_d = cnt_inc;
                end
            end
            ST_OWN_B: begin
                if (rel_b) begin
                    cnt_d  = '0;
                    prio_d = SEL_A;
                    if (ReqA)      state_d = ST_OWN_A;
                    else if (ReqB) state_d = ST_OWN_B;
                    else           state_d = ST_IDLE;
                end else if (beat_b) begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            prio_q  <= SEL_A;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
        end
    end

    assign GntA     = own_a;
    assign GntB     = own_b;
    assign Sel      = own_b ? SEL_B : SEL_A;
    assign OutValid = (own_a & ReqA) | (own_b & ReqB);

    Mux32Bit2To1 u_data_mux (
        .inA (DataA),
        .inB (DataB),
        .sel (Sel),
        .out (Out)
    );
endmodule

// File: doc/port_share_arbiter.md
# port_share_arbiter

Round-robin arbiter that shares one 32-bit datapath port between two requesters (A and B). It sits in front of the 32-bit 2:1 data mux.
- It owns the mux select line.
- It grants one requester at a time, for bursts of up to BURST_MAX beats.
- It presents the winner's word downstream with a valid/ready handshake.
- Typical use: the frame-buffer write port, shared between the pixel pipeline (A) and the host/config path (B).

## Interface
- BURST_MAX, 4, max beats per grant before forced re-arbitration; legal range 1..15
- Clk  in  1  system clock, rising-edge
- Reset  in  1  asynchronous, active-high reset
- ReqA  in  1  requester A has a valid word on DataA
- ReqB  in  1  requester B has a valid word on DataB
- LastA  in  1  current A word is the final beat of A's burst; sampled only on an A beat
- LastB  in  1  current B word is the final beat of B's burst; sampled only on a B beat
- DataA  in  32  requester A word
- DataB  in  32  requester B word
- Ready  in  1  downstream accepts Out this cycle
- GntA  out  1  A owns the port (registered)
- GntB  out  1  B owns the port (registered)
- Sel  out  1  mux select: 0 = A, 1 = B (registered, equals GntB)
- Out  out  32  selected word (combinational through the mux)
- OutValid  out  1  Out carries a valid beat

## Operation
- States: IDLE, OWN_A, OWN_B.
  - Encoding: IDLE = 2'b00, OWN_A = 2'b01, OWN_B = 2'b10.
  - 2'b11 is illegal and recovers to IDLE on the next clock.
- Registers:
  - state
  - beat counter cnt, width 4
  - round-robin pointer prio: 0 = A preferred, 1 = B preferred
- Beat definitions:
  - An A beat is a cycle with state = OWN_A, ReqA = 1 and Ready = 1.
  - A B beat is the same in OWN_B with ReqB = 1.
  - Each beat increments cnt.
- IDLE transitions:
  - Only ReqA -> OWN_A.
  - Only ReqB -> OWN_B.
  - Both requesting -> the owner is chosen by prio.
  - Neither requesting -> stay in IDLE.
- Release condition, evaluated in OWN_X each cycle, is any of:
  - a beat with LastX = 1;
  - a beat that makes cnt reach BURST_MAX;
  - ReqX = 0 (requester withdrew).
- On release:
  - cnt <= 0.
  - prio <= other requester.
  - If the other requester is requesting -> OWN_other, with no IDLE bubble.
  - Else if ReqX is still 1 (cap hit, or Last with more queued) -> stay OWN_X with a fresh burst.
  - Else -> IDLE.
- Outputs:
  - OutValid = (OWN_A & ReqA) | (OWN_B & ReqB).
  - Out = Sel ? DataB : DataA, valid only while OutValid = 1.
  - Ready does not affect OutValid. The requester holds Data and Req until a beat occurs.
- Non-owner behaviour: its Req is ignored for beats; its Data never reaches Out.

## Timing
- Reset values:
  - state = IDLE, GntA = 0, GntB = 0, Sel = 0, OutValid = 0.
  - cnt = 0, prio = 0 (A preferred).
  - Out = DataA, since Sel = 0.
- Grant latency: Req rising in IDLE -> Gnt high on the next rising edge (1 cycle).
  - The first beat can complete in that same granted cycle.
- Hand-over: on release with the other side requesting, the new Gnt/Sel appear on the edge that ends the releasing beat.
  - Zero idle cycles between bursts.
- Stall: Ready = 0 holds cnt, state and Sel; no beat is counted.
- Simultaneous events:
  - LastX and the cnt cap in the same beat -> a single release.
  - ReqA and ReqB rising together in IDLE -> prio decides.
- Reset asserted mid-burst: all state clears immediately (asynchronous).
  - The in-flight beat is dropped. Requesters must re-issue.
- Sel never changes in a cycle where OutValid = 1 and Ready = 0.

## Structure
- Shared package port_share_pkg holds:
  - state encoding constants ST_IDLE, ST_OWN_A, ST_OWN_B;
  - SEL_A = 0 and SEL_B = 1;
  - CNT_W = 4.
- One sub-module: the existing 32-bit 2:1 mux (Mux32Bit2To1), instance u_data_mux.
  - inA = DataA, inB = DataB, sel = Sel, out = Out.
- Arbiter FSM, counter and prio stay in one always block (asynchronous-reset flops) plus combinational next-state logic.

## Test plan
- Reset, then ReqA = 1 with Ready = 1 and DataA = 32'hAAAA0001..0006: GntA rises 1 cycle later; 4 beats pass; re-grant to A; beats 5–6 follow; Sel stays 0 throughout.
- ReqA = ReqB = 1 from IDLE after reset, Ready = 1, no Last: grants alternate A(4 beats), B(4), A(4).
  - Sel toggles on exact beat boundaries with no bubble.
  - Out matches DataA = 32'h1111_0000+n and DataB = 32'h2222_0000+n.
- A burst with LastA on beat 2 while ReqB = 1: GntB is asserted on the edge after beat 2; cnt restarts at 0.
- Ready held 0 for 5 cycles mid-B-burst: cnt, Sel and Out are frozen; OutValid stays 1; the burst resumes with the correct remaining beat count.
- Reset pulsed asynchronously (between edges) during beat 3 of OWN_B: GntB, Sel and OutValid drop to 0 immediately; after release, ReqA = ReqB = 1 grants A first (prio = A).
